// File: rtl/sdio_host_cmd.sv
// Host-side SDIO CMD-line engine: serialises a 48-bit command with CRC7, waits for
// the card's response start bit and deserialises/checks a 48- or 136-bit response.
module sdio_host_cmd #(
    parameter int NCR_MAX = 64,
    parameter int LGNCR   = 7
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_ckstb,
    input  logic         i_req,
    input  logic [5:0]   i_cmd,
    input  logic [31:0]  i_arg,
    input  logic [1:0]   i_rtype,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_timeout,
    output logic         o_crcerr,
    output logic [5:0]   o_resp_idx,
    output logic [119:0] o_resp,
    output logic         o_cmd_en,
    output logic         o_cmd,
    input  logic         i_cmd_pin,
    output logic [2:0]   o_dbg_state
);

    // Handshake: i_req is taken on any cycle with o_busy low; o_busy then stays high
    // through the single-cycle o_done pulse, after which a new i_req may be accepted.

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE} state_t;

    localparam logic [1:0] RT_NONE = 2'b00;
    localparam logic [1:0] RT_R2   = 2'b10;
    localparam logic [1:0] RT_R3   = 2'b11;

    state_t            state, state_nxt;
    logic [47:0]       tx_sr;
    logic [7:0]        bit_cnt;
    logic [LGNCR-1:0]  ncr_cnt;
    logic [133:0]      rx_sr;
    logic [134:0]      rx_full;
    logic [6:0]        rx_crc;
    logic [1:0]        rtype_q;
    logic              rx_last, in_crc, ncr_expired;
    logic              dec_dir, dec_end, dec_err;
    logic [5:0]        dec_idx;
    logic [6:0]        dec_crc;
    logic [119:0]      dec_resp;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_frame(input logic [39:0] f);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, f[i]);
        return c;
    endfunction

    assign o_done      = (state == S_DONE);
    assign o_dbg_state = state;

    // The start bit is never shifted in, so rx_full is indexed from the LSB end.
    assign rx_full     = {rx_sr, i_cmd_pin};
    assign rx_last     = (state == S_RX) && i_ckstb &&
                         (bit_cnt == ((rtype_q == RT_R2) ? 8'd135 : 8'd47));
    assign in_crc      = (rtype_q == RT_R2) ? (bit_cnt >= 8'd8 && bit_cnt <= 8'd127)
                                            : (bit_cnt >= 8'd1 && bit_cnt <= 8'd39);
    assign ncr_expired = (ncr_cnt == LGNCR'(NCR_MAX - 1));

    always_comb begin
        dec_dir  = 1'b0;
        dec_idx  = 6'h00;
        dec_resp = 120'h0;
        dec_crc  = 7'h00;
        dec_end  = 1'b0;
        if (rtype_q == RT_R2) begin
            dec_dir  = rx_full[134];
            dec_idx  = rx_full[133:128];
            dec_resp = rx_full[127:8];
        end else begin
            dec_dir  = rx_full[46];
            dec_idx  = rx_full[45:40];
            dec_resp = {88'h0, rx_full[39:8]};
        end
        dec_crc = rx_full[7:1];
        dec_end = rx_full[0];
        dec_err = dec_dir || !dec_end || ((rtype_q != RT_R3) && (dec_crc != rx_crc));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_req) state_nxt = S_TX;
            S_TX: begin
                if (i_ckstb && bit_cnt == 8'd47)
                    state_nxt = (rtype_q == RT_NONE) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (i_ckstb) begin
                    if (!i_cmd_pin)       state_nxt = S_RX;
                    else if (ncr_expired) state_nxt = S_DONE;
                end
            end
            S_RX:   if (rx_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_crcerr   <= 1'b0;
            o_cmd_en   <= 1'b0;
            o_cmd      <= 1'b1;
            o_resp     <= 120'h0;
            o_resp_idx <= 6'h00;
            tx_sr      <= 48'h0;
            bit_cnt    <= 8'd0;
            ncr_cnt    <= '0;
            rx_sr      <= '0;
            rx_crc     <= 7'h00;
            rtype_q    <= 2'b00;
        end else begin
            // The end bit stays on the pad for a full bit time, released at the next strobe.
            if (i_ckstb && state != S_TX) begin
                o_cmd_en <= 1'b0;
                o_cmd    <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        rtype_q   <= i_rtype;
                        tx_sr     <= {2'b01, i_cmd, i_arg, crc7_frame({2'b01, i_cmd, i_arg}), 1'b1};
                        bit_cnt   <= 8'd0;
                        o_busy    <= 1'b1;
                        o_timeout <= 1'b0;
                        o_crcerr  <= 1'b0;
                    end
                end
                S_TX: begin
                    if (i_ckstb) begin
                        o_cmd    <= tx_sr[47];
                        o_cmd_en <= 1'b1;
                        tx_sr    <= {tx_sr[46:0], 1'b0};
                        bit_cnt  <= bit_cnt + 8'd1;
                        ncr_cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_ckstb) begin
                        if (!i_cmd_pin) begin
                            bit_cnt <= 8'd1;
                            rx_crc  <= 7'h00;
                            rx_sr   <= '0;
                        end else if (ncr_expired) begin
                            o_timeout <= 1'b1;
                        end else begin
                            ncr_cnt <= ncr_cnt + 1'b1;
                        end
                    end
                end
                S_RX: begin
                    if (i_ckstb) begin
                        rx_sr   <= rx_full[133:0];
                        bit_cnt <= bit_cnt + 8'd1;
                        if (in_crc) rx_crc <= crc7_step(rx_crc, i_cmd_pin);
                        if (rx_last) begin
                            o_resp     <= dec_resp;
                            o_resp_idx <= dec_idx;
                            o_crcerr   <= dec_err;
                        end
                    end
                end
                S_DONE: o_busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_host_cmd.sv
// Bench for sdio_host_cmd: randomized strobe gaps, a card model built from frame
// rules, and a CRC7 reference computed by polynomial long division.
module tb_sdio_host_cmd;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_ckstb = 1'b0;
    logic         i_req = 1'b0;
    logic [5:0]   i_cmd = '0;
    logic [31:0]  i_arg = '0;
    logic [1:0]   i_rtype = '0;
    logic         i_cmd_pin = 1'b1;
    logic         o_busy, o_done, o_timeout, o_crcerr, o_cmd_en, o_cmd;
    logic [5:0]   o_resp_idx;
    logic [119:0] o_resp;
    logic [2:0]   o_dbg_state;

    int errors = 0;
    int checks = 0;

    logic [47:0]  last_tx;
    logic [119:0] exp_resp = '0;
    logic [5:0]   exp_idx = '0;

    sdio_host_cmd #(.NCR_MAX(64), .LGNCR(7)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ckstb(i_ckstb), .i_req(i_req),
        .i_cmd(i_cmd), .i_arg(i_arg), .i_rtype(i_rtype),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_crcerr(o_crcerr),
        .o_resp_idx(o_resp_idx), .o_resp(o_resp), .o_cmd_en(o_cmd_en), .o_cmd(o_cmd),
        .i_cmd_pin(i_cmd_pin), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Remainder of msg(x) * x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int n);
        logic [135:0] r;
        r = {msg, 7'b0} & ((136'h1 << (n + 7)) - 1);
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r = r ^ (136'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [135:0] make_r48(input logic [5:0] idx, input logic [31:0] arg);
        return {88'h0, 2'b00, idx, arg, crc7_div(128'({2'b00, idx, arg}), 40), 1'b1};
    endfunction

    function automatic logic [135:0] make_r2(input logic [119:0] cid);
        return {2'b00, 6'h3f, cid, crc7_div(128'(cid), 120), 1'b1};
    endfunction

    task automatic model_resp(input logic [135:0] f, input logic [1:0] rt, output logic err,
                              output logic [119:0] resp, output logic [5:0] idx);
        if (rt == 2'b10) begin
            idx  = f[133:128];
            resp = f[127:8];
            err  = f[134] || !f[0] || (crc7_div(128'(f[127:8]), 120) != f[7:1]);
        end else begin
            idx  = f[45:40];
            resp = {88'h0, f[39:8]};
            err  = f[46] || !f[0] ||
                   ((rt == 2'b01) && (crc7_div(128'(f[47:8]), 40) != f[7:1]));
        end
    endtask

    // One SD bit time: 0..5 idle cycles then a single strobe cycle; returns at a negedge.
    task automatic bit_time(input logic pin);
        int gap;
        gap = $urandom_range(0, 5);
        i_cmd_pin = pin;
        i_ckstb = 1'b0;
        repeat (gap) @(negedge clk);
        i_ckstb = 1'b1;
        @(negedge clk);
        i_ckstb = 1'b0;
    endtask

    task automatic accept(input logic [5:0] cmd, input logic [31:0] arg, input logic [1:0] rt);
        i_cmd = cmd; i_arg = arg; i_rtype = rt; i_req = 1'b1; i_cmd_pin = 1'b1;
        i_ckstb = 1'($urandom_range(0, 1));
        @(negedge clk);
        i_req = 1'b0; i_ckstb = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic [1:0] rt,
                           input bit silent, input logic [135:0] rframe, input int dly);
        logic [47:0]  exp_tx, got;
        bit           en_ok, early;
        int           len;
        logic         e_err;
        logic [119:0] e_resp;
        logic [5:0]   e_idx;
        exp_tx = {2'b01, cmd, arg, crc7_div(128'({2'b01, cmd, arg}), 40), 1'b1};
        accept(cmd, arg, rt);
        check("busy_on", o_busy, 1);
        check("flags_clr", {o_timeout, o_crcerr}, 0);
        en_ok = 1; early = 0;
        for (int i = 0; i < 48; i++) begin
            bit_time(1'b1);
            got[47-i] = o_cmd;
            if (!o_cmd_en) en_ok = 0;
            if (i < 47 && o_done) early = 1;
        end
        last_tx = got;
        check("tx_frame", got, exp_tx);
        check("tx_en", en_ok, 1);
        if (rt == 2'b00) begin
            check("done_tx", o_done, 1);
            check("flags_tx", {o_timeout, o_crcerr}, 0);
        end else if (silent) begin
            for (int i = 0; i < 64; i++) begin
                bit_time(1'b1);
                if (i < 63 && o_done) early = 1;
            end
            check("done_to", o_done, 1);
            check("timeout", o_timeout, 1);
            check("crcerr_to", o_crcerr, 0);
            check("resp_hold", o_resp, exp_resp);
            check("idx_hold", o_resp_idx, exp_idx);
        end else begin
            len = (rt == 2'b10) ? 136 : 48;
            for (int d = 0; d < dly; d++) begin
                bit_time(1'b1);
                if (o_done) early = 1;
            end
            for (int j = 0; j < len; j++) begin
                bit_time(rframe[len-1-j]);
                if (j < len - 1 && o_done) early = 1;
            end
            model_resp(rframe, rt, e_err, e_resp, e_idx);
            exp_resp = e_resp;
            exp_idx  = e_idx;
            check("done_rx", o_done, 1);
            check("timeout_rx", o_timeout, 0);
            check("crcerr", o_crcerr, e_err);
            check("resp", o_resp, exp_resp);
            check("resp_idx", o_resp_idx, exp_idx);
        end
        check("no_early_done", early, 0);
        i_cmd_pin = 1'b1;
        @(negedge clk);
        check("busy_off", o_busy, 0);
        check("done_pulse", o_done, 0);
    endtask

    initial begin
        logic [135:0] f;
        logic [119:0] cid;
        logic [1:0]   rt;
        int           len, pos;
        bit           seen_done;

        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_flags", {o_timeout, o_crcerr}, 0);
        check("rst_cmd_en", o_cmd_en, 0);
        check("rst_cmd", o_cmd, 1);
        check("rst_resp", o_resp, 0);
        check("rst_idx", o_resp_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(6'd0, 32'h0, 2'b00, 0, '0, 0);
        check("cmd0_const", last_tx, 48'h40_0000_0000_95);

        run_cmd(6'd8, 32'h1AA, 2'b01, 0, make_r48(6'd8, 32'h1AA), 3);
        check("cmd8_const", last_tx, 48'h48_0000_01AA_87);
        check("cmd8_arg", o_resp[31:0], 32'h1AA);
        check("cmd8_idx", o_resp_idx, 8);
        check("cmd8_crc", o_crcerr, 0);

        run_cmd(6'd17, 32'h0, 2'b01, 1, '0, 0);
        check("cmd17_const", last_tx, 48'h51_0000_0000_55);

        f = make_r48(6'h3f, 32'h80FF8000);
        f[7:1] = 7'($urandom);
        run_cmd(6'd41, 32'h40FF8000, 2'b11, 0, f, 5);
        check("r3_arg", o_resp[31:0], 32'h80FF8000);
        check("r3_crc_ignored", o_crcerr, 0);
        f[0] = 1'b0;
        run_cmd(6'd41, 32'h40FF8000, 2'b11, 0, f, 0);
        check("r3_bad_end", o_crcerr, 1);

        cid = {$urandom, $urandom, $urandom, 24'($urandom)};
        f = make_r2(cid);
        run_cmd(6'd2, 32'h0, 2'b10, 0, f, 2);
        check("r2_cid", o_resp, cid);
        check("r2_crc_ok", o_crcerr, 0);
        pos = 8 + $urandom_range(0, 119);
        f[pos] = ~f[pos];
        run_cmd(6'd2, 32'h0, 2'b10, 0, f, 1);
        check("r2_flip", o_crcerr, 1);

        for (int n = 0; n < 10; n++) begin
            rt = 2'($urandom_range(0, 3));
            if (rt == 2'b10) begin
                f = make_r2({$urandom, $urandom, $urandom, 24'($urandom)});
                len = 136;
            end else begin
                f = make_r48(6'($urandom), $urandom);
                if (rt == 2'b11) f[7:1] = 7'($urandom);
                len = 48;
            end
            if ($urandom_range(0, 2) == 0) begin
                pos = $urandom_range(0, len - 2);
                f[pos] = ~f[pos];
            end
            run_cmd(6'($urandom), $urandom, rt, 0, f, $urandom_range(0, 20));
        end

        // Reset in the middle of a command transmission.
        accept(6'd0, 32'h0, 2'b00);
        for (int i = 0; i < 20; i++) bit_time(1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_en", o_cmd_en, 0);
        check("mid_rst_busy", o_busy, 0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            i_ckstb = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_done) seen_done = 1;
        end
        i_ckstb = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_time(1'b1);
            if (o_done || o_cmd_en) seen_done = 1;
        end
        check("mid_rst_quiet", seen_done, 0);
        check("mid_rst_resp", o_resp, 0);
        exp_resp = '0;
        exp_idx  = '0;
        run_cmd(6'd0, 32'h0, 2'b00, 0, '0, 0);
        check("cmd0_after_rst", last_tx, 48'h40_0000_0000_95);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdio_host_cmd.md
Name: sdio_host_cmd

Overview:
- Host-side SDIO command-line engine.
- Serialises a 48-bit command (start, dir, index, argument, CRC7, end) onto CMD and waits up to NCR_MAX bit times for the card's response.
- Deserialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, checks framing and CRC7, and returns it to the host controller FSM.
- Sits between the host register interface and the CMD pad. Bit timing comes from an externally generated SD-clock strobe.

Parameters:
- NCR_MAX, 64: bit times allowed after command end before a missing response start bit is declared a timeout.
- LGNCR, 7: counter width for NCR wait; must satisfy 2^LGNCR > NCR_MAX.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_ckstb  in  1  one-cycle strobe at each SD clock rising edge; every CMD bit event happens only on this strobe
- i_req  in  1  start command; accepted only when !o_busy
- i_cmd  in  6  command index
- i_arg  in  32  command argument
- i_rtype  in  2  response type: 00 none, 01 R1 (48b, CRC checked), 10 R2 (136b, CRC checked), 11 R3 (48b, no CRC)
- o_busy  out  1  high from accept until o_done
- o_done  out  1  one-cycle completion pulse
- o_timeout  out  1  valid with o_done: no start bit within NCR_MAX
- o_crcerr  out  1  valid with o_done: CRC7 mismatch, dir bit != 0, or end bit != 1
- o_resp_idx  out  6  received index field (R2: reserved bits, expected 6'h3f)
- o_resp  out  120  received payload, right-justified; 48-bit types place argument in [31:0], upper bits zero
- o_cmd_en  out  1  CMD pad output enable
- o_cmd  out  1  CMD pad output value
- i_cmd_pin  in  1  CMD pad input, already synchronised

Behaviour:
- Reset (async assert, sync release) clears all outputs: o_busy, o_done, o_timeout, o_crcerr, and o_cmd_en = 0; o_cmd = 1; o_resp and o_resp_idx = 0. FSM goes to IDLE.
- Reset mid-transfer drops o_cmd_en immediately. Nothing completes, and no o_done is issued.
- States: IDLE, TX, WAIT, RX, DONE.
- IDLE, on i_req:
  - Latch i_cmd, i_arg, i_rtype.
  - Form the 40-bit frame {0, 1, cmd, arg} and compute CRC7 over it (poly x^7+x^3+1, init 0).
  - Set o_busy and go to TX. i_req while busy is ignored.
- TX: on each i_ckstb, drive the next bit MSB first: 40 frame bits, 7 CRC bits, then end bit 1.
  - o_cmd_en is high from the first bit through the end bit, i.e. 48 strobes.
  - After the end-bit strobe: rtype 00 goes to DONE; otherwise clear the NCR counter and go to WAIT.
- WAIT: on each i_ckstb, sample i_cmd_pin.
  - 0 is the start bit: go to RX with bit count 1.
  - Otherwise increment the counter. When it reaches NCR_MAX, set o_timeout and go to DONE.
  - The first WAIT sample is the strobe after the end bit, which gives Ncr min = 2 cycles counting bus turnaround.
- RX: shift in i_cmd_pin each strobe.
  - Total length is 48 bits, or 136 for R2.
  - CRC7 runs over bits 1..39 (R1) or over the 120 payload bits (R2).
  - At the last bit, set o_crcerr if dir != 0, end != 1, or CRC mismatch. For R3, CRC is not checked; dir and end still are.
  - Load o_resp and o_resp_idx, then go to DONE.
- DONE: pulse o_done for one cycle, clear o_busy, return to IDLE.
  - o_timeout, o_crcerr and o_resp hold until the next accept, which clears the flags.
- No i_ckstb means no progress. Stalls of any length are legal.
- i_ckstb on the same cycle as an accept does not emit a bit. The first bit goes out on the next strobe.

Test Plan:
- CMD0, arg 0, rtype 00: 48 bits on o_cmd equal 0x40_0000_0000_95. o_done arrives one cycle after the 48th strobe with no error flags.
- CMD8, arg 0x1AA, rtype 01: TX 0x48_0000_01AA_87. Card model echoes R7 0x08_0000_01AA plus correct CRC. Expect o_resp[31:0] = 0x1AA, o_resp_idx = 8, o_crcerr = 0.
- CMD17, arg 0, rtype 01, card silent: TX 0x51_0000_0000_55. o_done arrives after 64 WAIT strobes with o_timeout = 1 and o_resp unchanged.
- ACMD41, rtype 11: card returns idx 0x3f, arg 0x80FF8000 with arbitrary CRC bits. Expect o_resp[31:0] = 0x80FF8000 and o_crcerr = 0. Repeat with end bit 0: expect o_crcerr = 1.
- CMD2, rtype 10: model returns 120-bit CID. Expect o_resp = CID and o_crcerr = 0. Flip one payload bit: expect o_crcerr = 1.
- Assert reset at TX bit 20: expect o_cmd_en = 0 asynchronously and no o_done. A new CMD0 after release transmits correctly. Throughout, i_ckstb gaps of 0 to 5 cycles must not change the bit sequence.
